// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy-bird game slice.
// Contents:
//   BOARD_DIM    - board edge length in cells (16)
//   board_t      - 16x16 cell board indexed [row][col]; row 0 is the top, 1 = pipe
//   game_state_t - game FSM states IDLE / PLAY / OVER
package flappy_pkg;

    localparam int unsigned BOARD_DIM = 16;

    typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_t;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter that saturates at 99.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count to 00
//   clear - synchronous clear to 00
//   inc   - add one in BCD; a ones digit of 9 carries into the tens digit; holds at 99
//   q     - current count {tens, ones}
module bcd_counter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_q <= '0;
        end else if (inc && (r_q != 8'h99)) begin
            if (r_q[3:0] == 4'd9) begin
                r_q <= {r_q[7:4] + 4'd1, 4'd0};
            end else begin
                r_q[3:0] <= r_q[3:0] + 4'd1;
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/collision_scorer.sv
// Collision detection, pipe-pass scoring and frame compositing for the game.
// Parameters:
//   BIRD_COL  - board column (0..15) occupied by the bird
//   FLOOR_ROW - a bird_row at or above this value hits the floor
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   tick           - one-cycle strobe: shifted_green holds a newly shifted board
//   start          - one-cycle start/restart request (ignored while playing)
//   shifted_green  - pipe board [row][col], 1 = pipe
//   bird_row       - bird's current row
//   frame          - registered board with the bird pixel forced on
//   game_over      - registered, high in OVER
//   playing        - registered, high in PLAY
//   score_bcd      - registered two-digit BCD score
//   high_score_bcd - registered two-digit BCD best score
// Build option:
//   HIGH_SCORE_EN  - when defined, keeps the best score across games until rst;
//                    otherwise high_score_bcd is tied to 00.
module collision_scorer
    import flappy_pkg::*;
#(
    parameter int unsigned BIRD_COL  = 3,
    parameter int unsigned FLOOR_ROW = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                tick,
    input  logic                                start,
    input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0] shifted_green,
    input  logic [3:0]                          bird_row,
    output logic [BOARD_DIM-1:0][BOARD_DIM-1:0] frame,
    output logic                                game_over,
    output logic                                playing,
    output logic [7:0]                          score_bcd,
    output logic [7:0]                          high_score_bcd
);

    localparam logic [3:0] COL       = 4'(BIRD_COL);
    localparam logic [4:0] FLOOR_LIM = 5'(FLOOR_ROW);

    game_state_t r_state;
    game_state_t w_next;
    board_t      r_frame;
    board_t      w_frame;
    logic        r_game_over;
    logic        r_playing;
    logic        r_col_busy;
    logic        w_col_or;
    logic        w_hit;
    logic        w_score_clear;
    logic        w_score_inc;
    logic [7:0]  w_score;

    // Column occupancy at the bird's column and the collision condition.
    always_comb begin
        w_col_or = 1'b0;
        for (int unsigned r = 0; r < BOARD_DIM; r++) begin
            w_col_or = w_col_or | shifted_green[r[3:0]][COL];
        end
        w_hit = shifted_green[bird_row][COL] || ({1'b0, bird_row} >= FLOOR_LIM);
    end

    always_comb begin
        w_frame                = shifted_green;
        w_frame[bird_row][COL] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and score control; a collision on a pass tick wins and suppresses the increment.
    always_comb begin
        w_next        = r_state;
        w_score_clear = 1'b0;
        w_score_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next        = PLAY;
                    w_score_clear = 1'b1;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (w_hit) begin
                        w_next = OVER;
                    end else if (r_col_busy && !w_col_or) begin
                        w_score_inc = 1'b1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame     <= '0;
            r_game_over <= 1'b0;
            r_playing   <= 1'b0;
            r_col_busy  <= 1'b0;
        end else begin
            r_frame     <= w_frame;
            r_game_over <= (w_next == OVER);
            r_playing   <= (w_next == PLAY);
            if (tick) begin
                r_col_busy <= w_col_or;
            end
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .rst   (rst),
        .clear (w_score_clear),
        .inc   (w_score_inc),
        .q     (w_score)
    );

`ifdef HIGH_SCORE_EN
    logic [7:0] r_high;
    logic       w_to_over;

    assign w_to_over = (r_state == PLAY) && (w_next == OVER);

    // BCD digits order the same as binary, so a plain compare suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high <= '0;
        end else if (w_to_over && (w_score > r_high)) begin
            r_high <= w_score;
        end
    end

    assign high_score_bcd = r_high;
`else
    assign high_score_bcd = '0;
`endif

    assign frame     = r_frame;
    assign game_over = r_game_over;
    assign playing   = r_playing;
    assign score_bcd = w_score;

endmodule

// File: tb/tb_collision_scorer.sv
module tb_collision_scorer;
    import flappy_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    board_t     board = '0;
    logic [3:0] row = 4'd0;
    board_t     frame;
    logic       game_over;
    logic       playing;
    logic [7:0] score_bcd;
    logic [7:0] high_score_bcd;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    collision_scorer #(.BIRD_COL(3), .FLOOR_ROW(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .tick           (tick),
        .start          (start),
        .shifted_green  (board),
        .bird_row       (row),
        .frame          (frame),
        .game_over      (game_over),
        .playing        (playing),
        .score_bcd      (score_bcd),
        .high_score_bcd (high_score_bcd)
    );

    typedef struct {
        board_t     frame;
        logic       go;
        logic       pl;
        logic [7:0] sc;
        logic [7:0] hs;
    } exp_t;

    exp_t sbq[$];

    // Reference model: game rules in plain arithmetic.
    bit m_play = 0;
    bit m_over = 0;
    int m_score = 0;
    int m_high = 0;
    bit m_busy = 0;
    board_t m_frame = '0;

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: every cycle after an issued stimulus, compare outputs.
    always @(posedge clk) begin
        #1;
        if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("frame", 256'(frame), 256'(e.frame));
            chk("game_over", 256'(game_over), 256'(e.go));
            chk("playing", 256'(playing), 256'(e.pl));
            chk("score", 256'(score_bcd), 256'(e.sc));
            chk("high_score", 256'(high_score_bcd), 256'(e.hs));
        end
    end

    task automatic step(bit r, bit t, bit s, board_t b, logic [3:0] br);
        exp_t e;
        bit col_or, hit;
        @(negedge clk);
        rst = r; tick = t; start = s; board = b; row = br;
        col_or = 0;
        for (int i = 0; i < 16; i++) col_or |= b[i][3];
        hit = b[br][3] || (int'(br) >= 15);
        if (r) begin
            m_play = 0; m_over = 0; m_score = 0; m_high = 0; m_busy = 0; m_frame = '0;
        end else begin
            m_frame = b;
            m_frame[br][3] = 1'b1;
            if (!m_play && !m_over) begin
                if (s) begin m_play = 1; m_score = 0; end
            end else if (m_play) begin
                if (t) begin
                    if (hit) begin
                        m_play = 0; m_over = 1;
`ifdef HIGH_SCORE_EN
                        if (m_score > m_high) m_high = m_score;
`endif
                    end else if (m_busy && !col_or) begin
                        m_score = (m_score >= 99) ? 99 : m_score + 1;
                    end
                end
            end else if (s) begin
                m_over = 0;
            end
            if (t) m_busy = col_or;
        end
        e.frame = m_frame; e.go = m_over; e.pl = m_play;
        e.sc = to_bcd(m_score); e.hs = to_bcd(m_high);
        sbq.push_back(e);
    endtask

    board_t empty_b = '0;
    board_t pipe_b;
    board_t hit_b;

    task automatic do_pass(int n);
        for (int k = 0; k < n; k++) begin
            step(0, 1, 0, pipe_b, 4'd7);
            step(0, 1, 0, empty_b, 4'd7);
        end
    endtask

    task automatic game(int passes);
        step(0, 0, 1, empty_b, 4'd7);
        do_pass(passes);
        step(0, 1, 0, hit_b, 4'd7);
        step(0, 0, 1, empty_b, 4'd7);
    endtask

    initial begin
        pipe_b = '0;
        for (int i = 0; i < 16; i++) if (i <= 4 || i >= 10) pipe_b[i][3] = 1'b1;
        hit_b = '0;
        hit_b[7][3] = 1'b1;

        step(1, 0, 0, empty_b, 4'd0);
        step(1, 1, 1, pipe_b, 4'd2);
        step(0, 0, 1, empty_b, 4'd5);
        step(0, 1, 0, empty_b, 4'd5);
        do_pass(1);
        do_pass(8);
        do_pass(11);
        do_pass(85);
        step(0, 1, 0, hit_b, 4'd7);
        step(0, 1, 1, empty_b, 4'd7);
        step(0, 0, 1, empty_b, 4'd7);
        step(0, 1, 0, empty_b, 4'd15);
        step(0, 0, 1, empty_b, 4'd5);
        step(0, 0, 1, empty_b, 4'd5);
        do_pass(2);
        step(1, 1, 1, hit_b, 4'd7);
        step(0, 0, 0, empty_b, 4'd7);
        game(3);
        game(2);
        game(5);

        for (int n = 0; n < 600; n++) begin
            board_t b;
            logic [3:0] br;
            int mode, gap;
            for (int i = 0; i < 16; i++) b[i] = 16'($urandom);
            mode = int'($urandom_range(0, 3));
            gap = int'($urandom_range(0, 12));
            for (int i = 0; i < 16; i++) begin
                if (mode <= 1) b[i][3] = 1'b0;
                else if (mode == 2) b[i][3] = !(i >= gap && i < gap + 4);
            end
            br = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'(gap + 1);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), b, br);
        end

        step(0, 0, 0, empty_b, 4'd0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 256'(sbq.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
